// File: rtl/key_port_pkg.sv
// Register map and edge-capture mode encodings shared by the key debounce port.
package key_port_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK = 2'd1;
  localparam logic [1:0] ADDR_RSVD    = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  localparam int EDGE_FALL = 0;
  localparam int EDGE_RISE = 1;
  localparam int EDGE_BOTH = 2;

  // Keys are active-low: a falling stable level is a press, rising is a release.
  function automatic logic edge_hit(input int mode, input logic prev, input logic cur);
    case (mode)
      EDGE_FALL: edge_hit = prev & ~cur;
      EDGE_RISE: edge_hit = ~prev & cur;
      default:   edge_hit = prev ^ cur;
    endcase
  endfunction

endpackage

// File: rtl/key_debounce_port_if.sv
// Avalon-MM slave bus plus interrupt line of the key debounce port.
interface key_debounce_port_if;

  logic [1:0]  address;
  logic        chipselect;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, read, write, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, read, write, writedata,
    output readdata, irq
  );

endinterface

// File: rtl/key_debounce_chan.sv
// One key channel: 2-flop synchronizer, stability counter and accepted level.
module key_debounce_chan #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk_sys,
  input  logic rst_n,
  input  logic key_raw,
  output logic stable
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_q1;
  logic             sync_q2;
  logic [CNT_W-1:0] cnt;

  // The counter only runs while the synchronized level disagrees with the
  // accepted one, so any bounce back restarts the stability window.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
      stable  <= 1'b1;
      cnt     <= '0;
    end else begin
      sync_q1 <= key_raw;
      sync_q2 <= sync_q1;
      if (sync_q2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= sync_q2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/key_debounce_port.sv
// Debounced key port: per-key debounce channels, edge capture, mask and irq
// behind a four-word Avalon-MM register map.
module key_debounce_port
  import key_port_pkg::*;
#(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int EDGE_MODE       = EDGE_FALL
) (
  input  logic              CLOCK_50,
  input  logic              RESET_N,
  input  logic [N_KEYS-1:0] KEY,
  key_debounce_port_if.slave bus
);

  logic [N_KEYS-1:0] stable;
  logic [N_KEYS-1:0] stable_d;
  logic [N_KEYS-1:0] edge_set;
  logic [N_KEYS-1:0] cap_clr;
  logic [N_KEYS-1:0] irq_mask;
  logic [N_KEYS-1:0] edge_cap;
  logic [31:0]       rd_mux;
  logic              wr_en;
  logic              rd_en;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
    key_debounce_chan #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan (
      .clk_sys(CLOCK_50),
      .rst_n  (RESET_N),
      .key_raw(KEY[i]),
      .stable (stable[i])
    );
  end

  if (N_KEYS < 32) begin : g_wd_unused
    logic unused_wd;
    assign unused_wd = ^bus.writedata[31:N_KEYS];
  end

  assign wr_en   = bus.chipselect & bus.write;
  assign rd_en   = bus.chipselect & bus.read;
  assign cap_clr = (wr_en && bus.address == ADDR_EDGECAP) ? bus.writedata[N_KEYS-1:0] : '0;

  always_comb begin
    edge_set = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      edge_set[i] = edge_hit(EDGE_MODE, stable_d[i], stable[i]);
    end
  end

  always_comb begin
    rd_mux = '0;
    case (bus.address)
      ADDR_DATA:    rd_mux[N_KEYS-1:0] = stable;
      ADDR_IRQMASK: rd_mux[N_KEYS-1:0] = irq_mask;
      ADDR_EDGECAP: rd_mux[N_KEYS-1:0] = edge_cap;
      default:      rd_mux = '0;
    endcase
  end

  // A new capture outranks a same-cycle clear so no edge is ever lost.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      stable_d     <= '1;
      irq_mask     <= '0;
      edge_cap     <= '0;
      bus.readdata <= '0;
    end else begin
      stable_d <= stable;
      if (wr_en && bus.address == ADDR_IRQMASK) begin
        irq_mask <= bus.writedata[N_KEYS-1:0];
      end
      edge_cap <= (edge_cap & ~cap_clr) | edge_set;
      if (rd_en) begin
        bus.readdata <= rd_mux;
      end
    end
  end

  assign bus.irq = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_key_debounce_port.sv
// Directed bench: falling-edge instance driven by a vector table, plus a
// both-edge instance sharing the keys for the multi-capture and reset cases.
module tb_key_debounce_port;
  import key_port_pkg::*;

  localparam int N_KEYS = 4;
  localparam int DEB    = 4;

  typedef struct {
    bit          is_wr;
    logic [3:0]  key;
    int          settle;
    logic [1:0]  addr;
    logic [31:0] data;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N_KEYS-1:0] key = '1;
  int                checks = 0;
  int                errors = 0;
  vec_t              vecs[$];
  logic [31:0]       rd;

  key_debounce_port_if bus_a();
  key_debounce_port_if bus_b();

  always #5 clk = ~clk;

  key_debounce_port #(.N_KEYS(N_KEYS), .DEBOUNCE_CYCLES(DEB), .EDGE_MODE(EDGE_FALL)) dut_a (
    .CLOCK_50(clk), .RESET_N(rst_n), .KEY(key), .bus(bus_a)
  );

  key_debounce_port #(.N_KEYS(N_KEYS), .DEBOUNCE_CYCLES(DEB), .EDGE_MODE(EDGE_BOTH)) dut_b (
    .CLOCK_50(clk), .RESET_N(rst_n), .KEY(key), .bus(bus_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bus_idle();
    bus_a.chipselect = 1'b0; bus_b.chipselect = 1'b0;
    bus_a.read = 1'b0;       bus_b.read = 1'b0;
    bus_a.write = 1'b0;      bus_b.write = 1'b0;
    bus_a.address = '0;      bus_b.address = '0;
    bus_a.writedata = '0;    bus_b.writedata = '0;
  endtask

  task automatic bus_cycle(input logic cs_a, input logic cs_b, input logic rd_s, input logic wr_s,
                           input logic [1:0] a, input logic [31:0] wd);
    bus_a.chipselect = cs_a; bus_b.chipselect = cs_b;
    bus_a.read = rd_s;       bus_b.read = rd_s;
    bus_a.write = wr_s;      bus_b.write = wr_s;
    bus_a.address = a;       bus_b.address = a;
    bus_a.writedata = wd;    bus_b.writedata = wd;
    @(negedge clk);
    bus_idle();
  endtask

  task automatic reg_write(input int inst, input logic [1:0] a, input logic [31:0] wd);
    bus_cycle(inst == 0, inst == 1, 1'b0, 1'b1, a, wd);
  endtask

  task automatic read_check(input int inst, input logic [1:0] a, input logic [31:0] exp,
                            input string name);
    logic [31:0] d;
    bus_cycle(inst == 0, inst == 1, 1'b1, 1'b0, a, 32'h0);
    d = (inst == 0) ? bus_a.readdata : bus_b.readdata;
    check(name, d, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic vec_t mk(input bit w, input logic [3:0] k, input int s,
                              input logic [1:0] a, input logic [31:0] d);
    vec_t v;
    v.is_wr = w; v.key = k; v.settle = s; v.addr = a; v.data = d;
    return v;
  endfunction

  initial begin
    // key applied at the start of each entry, held for settle cycles, then one bus access
    vecs.push_back(mk(0, 4'hF, 0, ADDR_DATA,    32'h0000_000F));
    vecs.push_back(mk(0, 4'hF, 0, ADDR_IRQMASK, 32'h0));
    vecs.push_back(mk(0, 4'hF, 0, ADDR_EDGECAP, 32'h0));
    vecs.push_back(mk(0, 4'hF, 0, ADDR_RSVD,    32'h0));
    vecs.push_back(mk(1, 4'hF, 0, ADDR_RSVD,    32'hFFFF_FFFF));
    vecs.push_back(mk(0, 4'hF, 0, ADDR_RSVD,    32'h0));
    vecs.push_back(mk(1, 4'hF, 0, ADDR_IRQMASK, 32'hFFFF_FFFF));
    vecs.push_back(mk(0, 4'hF, 0, ADDR_IRQMASK, 32'h0000_000F));
    vecs.push_back(mk(1, 4'hF, 0, ADDR_IRQMASK, 32'h0));
    vecs.push_back(mk(0, 4'hF, 0, ADDR_IRQMASK, 32'h0));
    vecs.push_back(mk(0, 4'hD, 5, ADDR_DATA,    32'h0000_000F));
    vecs.push_back(mk(0, 4'hD, 0, ADDR_DATA,    32'h0000_000D));
    vecs.push_back(mk(0, 4'hD, 0, ADDR_EDGECAP, 32'h0000_0002));
    vecs.push_back(mk(0, 4'hD, 0, ADDR_EDGECAP, 32'h0000_0002));
    vecs.push_back(mk(1, 4'hD, 0, ADDR_EDGECAP, 32'h0000_0002));
    vecs.push_back(mk(0, 4'hD, 0, ADDR_EDGECAP, 32'h0));
    vecs.push_back(mk(0, 4'h9, 2, ADDR_DATA,    32'h0000_000D));
    vecs.push_back(mk(0, 4'hD, 8, ADDR_DATA,    32'h0000_000D));
    vecs.push_back(mk(0, 4'hD, 0, ADDR_EDGECAP, 32'h0));
    vecs.push_back(mk(0, 4'hF, 8, ADDR_DATA,    32'h0000_000F));
    vecs.push_back(mk(0, 4'hF, 0, ADDR_EDGECAP, 32'h0));

    bus_idle();
    cycles(3);
    check("rst_readdata_a", bus_a.readdata, 32'h0);
    check("rst_readdata_b", bus_b.readdata, 32'h0);
    check("rst_irq_a", {31'h0, bus_a.irq}, 32'h0);
    rst_n = 1'b1;
    cycles(2);

    for (int i = 0; i < vecs.size(); i++) begin
      key = vecs[i].key;
      cycles(vecs[i].settle);
      if (vecs[i].is_wr) reg_write(0, vecs[i].addr, vecs[i].data);
      else read_check(0, vecs[i].addr, vecs[i].data, $sformatf("vec%0d", i));
    end

    // readdata holds without a read; deselected accesses are ignored
    read_check(0, ADDR_DATA, 32'h0000_000F, "hold_base");
    cycles(3);
    check("hold_idle", bus_a.readdata, 32'h0000_000F);
    bus_cycle(1'b0, 1'b0, 1'b1, 1'b0, ADDR_EDGECAP, 32'h0);
    check("hold_cs_low_read", bus_a.readdata, 32'h0000_000F);
    bus_cycle(1'b0, 1'b0, 1'b0, 1'b1, ADDR_IRQMASK, 32'hF);
    read_check(0, ADDR_IRQMASK, 32'h0, "cs_low_write");

    // masked capture raises irq, clearing EDGECAP drops it
    reg_write(0, ADDR_IRQMASK, 32'h2);
    key = 4'hD;
    cycles(6);
    check("irq_before_cap", {31'h0, bus_a.irq}, 32'h0);
    cycles(1);
    check("irq_on_cap", {31'h0, bus_a.irq}, 32'h1);
    check("irq_b_unmasked", {31'h0, bus_b.irq}, 32'h0);
    reg_write(0, ADDR_EDGECAP, 32'h2);
    check("irq_after_clr", {31'h0, bus_a.irq}, 32'h0);
    key = 4'hF;
    cycles(8);
    check("irq_release_mode0", {31'h0, bus_a.irq}, 32'h0);
    reg_write(0, ADDR_IRQMASK, 32'h0);

    // clear colliding with capture on the same edge
    key = 4'h7;
    cycles(6);
    reg_write(0, ADDR_EDGECAP, 32'h8);
    read_check(0, ADDR_EDGECAP, 32'h8, "set_beats_clr");
    reg_write(0, ADDR_EDGECAP, 32'h8);
    read_check(0, ADDR_EDGECAP, 32'h0, "clr_after_collision");
    key = 4'hF;
    cycles(8);

    // both-edge instance: press and release each captured
    reg_write(1, ADDR_EDGECAP, 32'hF);
    reg_write(0, ADDR_EDGECAP, 32'hF);
    reg_write(1, ADDR_IRQMASK, 32'h1);
    key = 4'hE;
    cycles(6);
    check("both_press_pre", {31'h0, bus_b.irq}, 32'h0);
    cycles(1);
    check("both_press_irq", {31'h0, bus_b.irq}, 32'h1);
    read_check(1, ADDR_EDGECAP, 32'h1, "both_press_cap");
    reg_write(1, ADDR_EDGECAP, 32'h1);
    check("both_press_clr", {31'h0, bus_b.irq}, 32'h0);
    key = 4'hF;
    cycles(6);
    check("both_rel_pre", {31'h0, bus_b.irq}, 32'h0);
    cycles(1);
    check("both_rel_irq", {31'h0, bus_b.irq}, 32'h1);
    read_check(1, ADDR_EDGECAP, 32'h1, "both_rel_cap");
    reg_write(1, ADDR_EDGECAP, 32'h1);
    check("both_rel_clr", {31'h0, bus_b.irq}, 32'h0);
    read_check(0, ADDR_EDGECAP, 32'h1, "fall_only_cap");
    reg_write(0, ADDR_EDGECAP, 32'h1);

    // reset pulse in the middle of the release debounce
    reg_write(0, ADDR_IRQMASK, 32'h1);
    reg_write(1, ADDR_IRQMASK, 32'h1);
    key = 4'hE;
    cycles(8);
    reg_write(0, ADDR_EDGECAP, 32'hF);
    reg_write(1, ADDR_EDGECAP, 32'hF);
    read_check(1, ADDR_DATA, 32'h0000_000E, "pre_abort_data");
    key = 4'hF;
    cycles(3);
    rst_n = 1'b0;
    #1;
    check("abort_readdata_b", bus_b.readdata, 32'h0);
    check("abort_irq_b", {31'h0, bus_b.irq}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cycles(10);
    read_check(0, ADDR_DATA, 32'h0000_000F, "abort_data_a");
    read_check(1, ADDR_DATA, 32'h0000_000F, "abort_data_b");
    read_check(1, ADDR_EDGECAP, 32'h0, "abort_cap_b");
    read_check(0, ADDR_EDGECAP, 32'h0, "abort_cap_a");
    read_check(1, ADDR_IRQMASK, 32'h0, "abort_mask_b");
    check("abort_irq_after", {31'h0, bus_b.irq}, 32'h0);

    // key held through reset release is debounced normally and captured
    rst_n = 1'b0;
    key = 4'hB;
    cycles(2);
    rst_n = 1'b1;
    cycles(5);
    read_check(0, ADDR_DATA, 32'h0000_000F, "held_data_early");
    read_check(0, ADDR_DATA, 32'h0000_000B, "held_data");
    read_check(0, ADDR_EDGECAP, 32'h0000_0004, "held_cap");
    key = 4'hF;
    cycles(8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_debounce_port.md
KEY_DEBOUNCE_PORT -- requirements
Module: key_debounce_port

Interface
REQ-001 SHALL have parameter N_KEYS, default 4, number of key channels (1..32).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 500000, stable cycles required before accepting a level change (>=2; 10 ms at 50 MHz).
REQ-003 SHALL have parameter EDGE_MODE, default 0, capture mode: 0 falling (press), 1 rising (release), 2 both.
REQ-004 CLOCK_50  in  1  single clock; all logic rising-edge.
REQ-005 RESET_N  in  1  asynchronous, active-low reset.
REQ-006 KEY  in  N_KEYS  raw active-low board keys, asynchronous to CLOCK_50.
REQ-007 address  in  2  Avalon-MM slave word address.
REQ-008 chipselect  in  1  slave select; read/write are ignored when low.
REQ-009 read  in  1  read strobe.
REQ-010 write  in  1  write strobe.
REQ-011 writedata  in  32  write data.
REQ-012 readdata  out  32  read data, valid one cycle after read.
REQ-013 irq  out  1  level interrupt request.

Function
REQ-014 Each KEY bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-015 Each channel SHALL hold a stable level and a counter of width $clog2(DEBOUNCE_CYCLES).
REQ-016 When synchronized level equals stable level, the counter SHALL clear to 0.
REQ-017 When they differ, the counter SHALL increment; on the cycle it equals DEBOUNCE_CYCLES-1, stable SHALL take the synchronized level and the counter SHALL clear.
REQ-018 A bounce back to the stable level before acceptance SHALL clear the counter with no stable change.
REQ-019 Latency from a clean KEY change to stable change SHALL be exactly 2 + DEBOUNCE_CYCLES cycles.
REQ-020 Register map: 0 DATA (RO, stable levels in bits [N_KEYS-1:0]); 1 IRQMASK (RW); 2 reserved (reads 0, writes ignored); 3 EDGECAP (read; write-1-to-clear).
REQ-021 Bits at and above N_KEYS SHALL read 0 in every register.
REQ-022 An edge of the stable level matching EDGE_MODE SHALL set the corresponding EDGECAP bit on the cycle after the stable change.
REQ-023 A set and a write-1-clear of the same EDGECAP bit in the same cycle SHALL leave the bit set.
REQ-024 irq SHALL equal OR over (EDGECAP AND IRQMASK), driven from registers only.
REQ-025 readdata SHALL be registered; it SHALL hold its last value when no read is issued.
REQ-026 A read of EDGECAP SHALL NOT clear it.

Reset
REQ-027 While RESET_N is low: synchronizers and stable levels = all 1 (released), counters = 0, IRQMASK = 0, EDGECAP = 0, readdata = 0, irq = 0.
REQ-028 Reset asserted mid-debounce SHALL abort the count; no edge SHALL be captured from the aborted change.
REQ-029 Keys held pressed at reset release SHALL be accepted after the normal debounce and produce a falling edge.

Structure
REQ-030 Package key_port_pkg SHALL hold register address constants (ADDR_DATA, ADDR_IRQMASK, ADDR_EDGECAP) and EDGE_MODE encodings.
REQ-031 One sub-module key_debounce_chan SHALL implement synchronizer, counter and stable level for one channel, instantiated N_KEYS times by generate.
REQ-032 Edge detect, registers, bus decode and irq SHALL reside in key_debounce_port.

Verification (bench with N_KEYS=4, DEBOUNCE_CYCLES=4)
REQ-033 KEY[1] 1->0 held -> DATA reads 4'b1101 after 6 cycles; EDGECAP reads 4'b0010.
REQ-034 KEY[2] pulses low 3 cycles then high -> DATA stays 4'b1111; EDGECAP stays 0.
REQ-035 IRQMASK=4'b0010, KEY[1] press -> irq=1; write EDGECAP=4'b0010 -> irq=0 next cycle.
REQ-036 Write-1-clear of bit 3 in same cycle as KEY[3] edge capture -> EDGECAP bit 3 reads 1.
REQ-037 EDGE_MODE=2, KEY[0] press then release -> two captures, each cleared in between; irq asserts twice.
REQ-038 RESET_N low for 1 cycle during 2nd debounce count of KEY[0] -> all registers 0, DATA 4'b1111, no edge captured.
